pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers.
- One generic pipeline boundary with a valid/ready handshake on both sides, a 2-entry skid buffer and flush.
- The skid buffer makes upstream ready a registered signal, so stall paths no longer ripple combinationally through the whole pipe.
- Control bits are forced to zero whenever the stage holds a bubble; payload bits are held. This keeps the existing bubble-insertion semantics.

Parameters:
- DATA_W, 32: payload width (PC, operands, immediates). Never cleared by bubble or flush.
- CTRL_W, 8: control width (RegWrite, MemRead, MemWrite, Trap, ...). Output is zero whenever out_valid=0.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled at the rising edge of clk.
- flush  in  1  kills all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control; zero when out_valid=0.
- out_data  out  DATA_W  payload; holds last value when invalid.
- occupancy  out  2  held entries: 0, 1 or 2.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage
  - Main register M: m_valid, m_ctrl, m_data.
  - Skid register S: s_valid, s_ctrl, s_data.
  - out_valid=m_valid; out_ctrl = m_valid ? m_ctrl : 0; out_data = m_data.
- Registered ready: in_ready = ~s_valid, driven straight from a flop. No combinational path from out_ready to in_ready.
- Handshakes
  - acc = in_valid & in_ready & ~flush.
  - drn = m_valid & out_ready.
- States: EMPTY (m_valid=0, s_valid=0), ONE (m_valid=1, s_valid=0), FULL (m_valid=1, s_valid=1). occupancy = 0/1/2 respectively.
- Transitions, all evaluated at the clk edge with rst=1 and flush=0:
  - EMPTY: acc -> M<=in, go to ONE. Otherwise stay. out_ready is ignored.
  - ONE:
    - acc & drn -> M<=in, stay in ONE. Back-to-back throughput is 1 entry per cycle.
    - acc & ~drn -> S<=in, go to FULL; in_ready falls next cycle.
    - ~acc & drn -> go to EMPTY; m_data is held.
    - ~acc & ~drn -> hold.
  - FULL: in_ready=0, so acc=0.
    - drn -> M<=S, s_valid<=0, go to ONE; in_ready rises next cycle.
    - ~drn -> hold.
- Ordering: entries leave strictly in acceptance order. S is always younger than M.
- Latency: an entry accepted into EMPTY appears on out_* in the next cycle.
- Flush (rst=1, flush=1)
  - m_valid<=0 and s_valid<=0; next state EMPTY; in_ready=1 next cycle.
  - Any input offered in the same cycle is discarded and never appears on the output.
  - An output handshake in the same cycle (drn=1) is still a valid transfer downstream.
  - Data registers hold their values.
- Reset (rst=0 at the edge) has priority over flush and all handshakes:
  - m_valid, s_valid, m_ctrl, s_ctrl, m_data, s_data and stall_cnt <= 0.
  - State goes to EMPTY; in_ready=1 after the edge.
  - Outputs after the reset edge: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
  - Reset asserted mid-transfer drops every held entry without a downstream handshake.
- Stall counter
  - Increments by 1 on each edge where out_valid & ~out_ready, including during a flush edge.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Widths: all data paths are exact-width copies; no sign extension or truncation is performed.

Test Plan:
- Reset then stream: rst=0 for 2 cycles, then rst=1; in_valid=1 with data 0x10,0x11,0x12, ctrl 0x81; out_ready=1 -> out_data 0x10,0x11,0x12 on the three cycles after acceptance; out_ctrl=0x81; in_ready=1 throughout; occupancy stays 1; stall_cnt=0.
- Backpressure fill: out_ready=0; send 0xA0 then 0xA1 -> occupancy 1 then 2; in_ready=0 from the cycle after 0xA1 is accepted. Release out_ready -> out_data 0xA0 then 0xA1; in_ready=1 one cycle after the first drain; stall_cnt equals the number of out_valid=1 & out_ready=0 cycles.
- Bubble masking: after the last entry drains with in_valid=0 -> out_valid=0, out_ctrl=0x00, out_data still 0xA1.
- Flush while FULL with in_valid=1 and data 0xB2 -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xB2 never appears on the output.
- Stall counter saturation: CNT_W=2, out_valid=1, out_ready=0 for 5 cycles -> stall_cnt reads 1,2,3,3,3.
- Reset mid-FULL: rst=0 with occupancy=2 -> next cycle out_valid=0, out_data=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Generic pipeline boundary: valid/ready on both sides, 2-entry skid buffer,
// registered upstream ready, flush, and a saturating downstream stall counter.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic m_valid;
  logic acc;
  logic drn;

  assign m_valid = (state_q != EMPTY);
  assign acc     = in_valid & in_ready_q & ~flush;
  assign drn     = m_valid & out_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    m_ctrl_d    = m_ctrl_q;
    m_data_d    = m_data_q;
    s_ctrl_d    = s_ctrl_q;
    s_data_d    = s_data_q;
    stall_cnt_d = stall_cnt_q;

    if (m_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (flush) begin
      // Held payloads stay put; only the valid state is killed.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
            state_d  = ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (acc) begin
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
            state_d  = FULL;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Ready is precomputed from the next state so it leaves the design as a flop.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the payload registers are cleared too, so out_data reads zero
      // straight after reset rather than stale contents.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      s_ctrl_q    <= '0;
      s_data_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    unique case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a driver pushes expected entries into a
// queue, a negedge monitor pops and compares on every downstream handshake.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  logic              sat_in_ready;
  logic              sat_out_valid;
  logic [CTRL_W-1:0] sat_out_ctrl;
  logic [DATA_W-1:0] sat_out_data;
  logic [1:0]        sat_occupancy;
  logic [1:0]        sat_stall_cnt;

  entry_t exp_q[$];
  int     total = 0;
  int     bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  // Narrow-counter copy fed the same stimulus, used for the saturation check.
  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (sat_out_ctrl),
    .out_data  (sat_out_data),
    .occupancy (sat_occupancy),
    .stall_cnt (sat_stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    if (expect_out) exp_q.push_back('{ctrl: c, data: d});
  endtask

  // Monitor: a handshake visible at negedge completes at the next posedge.
  always @(negedge clk) begin
    entry_t e;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {32'h0, out_data}, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {32'h0, out_data}, {32'h0, e.data});
        check("out_ctrl", {56'h0, out_ctrl}, {56'h0, e.ctrl});
      end
    end
  end

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_ctrl",  {56'h0, out_ctrl},  64'h0);
    check("rst_out_data",  {32'h0, out_data},  64'h0);
    check("rst_occupancy", {62'h0, occupancy}, 64'h0);
    check("rst_stall_cnt", {48'h0, stall_cnt}, 64'h0);
    check("rst_in_ready",  {63'h0, in_ready},  64'h1);
    rst = 1'b1;

    // Stream at full throughput.
    out_ready = 1'b1;
    offer(8'h81, 32'h10, 1'b1);
    step();
    check("s0_data", {32'h0, out_data}, 64'h10);
    check("s0_occ",  {62'h0, occupancy}, 64'h1);
    check("s0_rdy",  {63'h0, in_ready},  64'h1);
    offer(8'h81, 32'h11, 1'b1);
    step();
    check("s1_data", {32'h0, out_data}, 64'h11);
    check("s1_occ",  {62'h0, occupancy}, 64'h1);
    offer(8'h81, 32'h12, 1'b1);
    step();
    check("s2_data", {32'h0, out_data}, 64'h12);
    check("s2_ctrl", {56'h0, out_ctrl}, 64'h81);
    check("s2_rdy",  {63'h0, in_ready},  64'h1);
    in_valid = 1'b0;
    step();
    check("s_end_occ",   {62'h0, occupancy}, 64'h0);
    check("s_end_stall", {48'h0, stall_cnt}, 64'h0);

    // Backpressure fill then release.
    out_ready = 1'b0;
    offer(8'h42, 32'hA0, 1'b1);
    step();
    check("bp_occ1", {62'h0, occupancy}, 64'h1);
    check("bp_rdy1", {63'h0, in_ready},  64'h1);
    offer(8'h42, 32'hA1, 1'b1);
    step();
    check("bp_occ2",  {62'h0, occupancy}, 64'h2);
    check("bp_rdy2",  {63'h0, in_ready},  64'h0);
    check("bp_head",  {32'h0, out_data},  64'hA0);
    check("bp_stall1",{48'h0, stall_cnt}, 64'h1);
    in_valid = 1'b0;
    step();
    check("bp_hold_rdy",  {63'h0, in_ready},  64'h0);
    check("bp_stall2",    {48'h0, stall_cnt}, 64'h2);
    out_ready = 1'b1;
    step();
    check("bp_drain1_data", {32'h0, out_data},  64'hA1);
    check("bp_drain1_rdy",  {63'h0, in_ready},  64'h1);
    check("bp_drain1_occ",  {62'h0, occupancy}, 64'h1);
    step();
    check("bub_valid", {63'h0, out_valid}, 64'h0);
    check("bub_ctrl",  {56'h0, out_ctrl},  64'h0);
    check("bub_data",  {32'h0, out_data},  64'hA1);
    check("bub_stall", {48'h0, stall_cnt}, 64'h2);

    // Flush while FULL; none of B0/B1/B2 may reach the output.
    out_ready = 1'b0;
    offer(8'h33, 32'hB0, 1'b0);
    step();
    offer(8'h33, 32'hB1, 1'b0);
    step();
    check("fl_full_occ", {62'h0, occupancy}, 64'h2);
    flush = 1'b1;
    offer(8'h33, 32'hB2, 1'b0);
    step();
    check("fl_valid", {63'h0, out_valid}, 64'h0);
    check("fl_occ",   {62'h0, occupancy}, 64'h0);
    check("fl_rdy",   {63'h0, in_ready},  64'h1);
    check("fl_ctrl",  {56'h0, out_ctrl},  64'h0);
    check("fl_data",  {32'h0, out_data},  64'hB0);
    check("fl_stall", {48'h0, stall_cnt}, 64'h4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    check("fl_after_valid", {63'h0, out_valid}, 64'h0);

    // Saturation on the 2-bit counter; reset both instances first.
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("sat_rst", {62'h0, sat_stall_cnt}, 64'h0);
    out_ready = 1'b0;
    offer(8'h01, 32'hC0, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("sat_cnt%0d", i), {62'h0, sat_stall_cnt}, {62'h0, sat_exp[i]});
      check($sformatf("wide_cnt%0d", i), {48'h0, stall_cnt}, 64'(i + 1));
    end

    // Reset while FULL drops both entries.
    offer(8'h01, 32'hC1, 1'b0);
    step();
    check("rf_occ", {62'h0, occupancy}, 64'h2);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rf_valid", {63'h0, out_valid}, 64'h0);
    check("rf_data",  {32'h0, out_data},  64'h0);
    check("rf_stall", {48'h0, stall_cnt}, 64'h0);
    check("rf_rdy",   {63'h0, in_ready},  64'h1);
    check("rf_occ0",  {62'h0, occupancy}, 64'h0);
    rst = 1'b1; out_ready = 1'b1;
    step();
    check("rf_after_valid", {63'h0, out_valid}, 64'h0);

    // One more entry after reset: one-cycle latency, full-width values.
    offer(8'hFF, 32'hFFFF_FFFF, 1'b1);
    step();
    check("post_valid", {63'h0, out_valid}, 64'h1);
    check("post_data",  {32'h0, out_data},  64'hFFFF_FFFF);
    in_valid = 1'b0;
    step(); step();
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
